// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param
//   Genius-style memory game core: control FSM and datapath in one block.
//   Each round appends one LFSR-generated element to the stored sequence,
//   replays the whole sequence on the LEDs, then checks the player's presses
//   one by one with a per-press timeout.
//
// Parameters
//   N_BOTOES       number of buttons/LEDs (power of 2, 2..16)
//   MAX_SEQ        maximum sequence length (power of 2, 4..256)
//   TEMPO_LED      cycles an LED stays lit during replay, and dark between LEDs
//   TIMEOUT_CICLOS cycles allowed per press before timeout (>= 2)
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   jogar         in   starts a game from INICIAL or any FIM state
//   nivel         in   0: game length MAX_SEQ/2, 1: MAX_SEQ (sampled in PREPARA)
//   semente       in   LFSR seed (sampled in PREPARA, 0 replaced by 16'hACE1)
//   botoes        in   player buttons, one-hot expected
//   leds          out  one-hot replay display
//   ganhou        out  high in FIM_GANHOU
//   perdeu        out  high in FIM_PERDEU
//   timeout       out  high in FIM_TIMEOUT
//   pronto        out  high in any FIM state
//   db_estado     out  current state code
//   db_sequencia  out  current round index (round length - 1)
//   db_contagem   out  current element index
module jogo_memoria_param #(
    parameter int N_BOTOES       = 4,
    parameter int MAX_SEQ        = 16,
    parameter int TEMPO_LED      = 1000,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int BW = $clog2(N_BOTOES),
    localparam int AW = $clog2(MAX_SEQ)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                nivel,
    input  logic [15:0]         semente,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic                pronto,
    output logic [3:0]          db_estado,
    output logic [AW-1:0]       db_sequencia,
    output logic [AW-1:0]       db_contagem
);

    localparam int TMAX = (TEMPO_LED > TIMEOUT_CICLOS) ? TEMPO_LED : TIMEOUT_CICLOS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] LED_FIM = TW'(TEMPO_LED - 1);
    localparam logic [TW-1:0] TO_FIM  = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [15:0]   SEMENTE_PADRAO = 16'hACE1;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        NOVO        = 4'h2,
        MOSTRA      = 4'h3,
        APAGA       = 4'h4,
        ESPERA      = 4'h5,
        REGISTRA    = 4'h6,
        COMPARA     = 4'h7,
        FIM_GANHOU  = 4'hA,
        FIM_PERDEU  = 4'hB,
        FIM_TIMEOUT = 4'hC
    } estado_t;

    estado_t             estado;
    logic [BW-1:0]       mem [MAX_SEQ];
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_nxt;
    logic [AW-1:0]       seq;
    logic [AW-1:0]       idx;
    logic [AW-1:0]       limite;
    logic [TW-1:0]       timer;
    logic [N_BOTOES-1:0] prev;
    logic [N_BOTOES-1:0] jogada;
    logic                tem_jogada;
    logic [BW-1:0]       primeiro;

    function automatic logic [N_BOTOES-1:0] onehot(input logic [BW-1:0] v);
        logic [N_BOTOES-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    assign lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // Single-cycle pulse on the press edge; a held button never re-triggers.
    assign tem_jogada = (prev == '0) && (botoes != '0);

    // In NOVO the first replayed element may be the one being written this
    // very cycle (round 0), so bypass the memory in that case.
    assign primeiro = (seq == '0) ? lfsr[BW-1:0] : mem[0];

    assign db_estado    = estado;
    assign db_sequencia = seq;
    assign db_contagem  = idx;

    // Sequence memory: no reset, contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (estado == NOVO) begin
            mem[seq] <= lfsr[BW-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= INICIAL;
            lfsr    <= SEMENTE_PADRAO;
            seq     <= '0;
            idx     <= '0;
            limite  <= '0;
            timer   <= '0;
            prev    <= '0;
            jogada  <= '0;
            leds    <= '0;
            ganhou  <= 1'b0;
            perdeu  <= 1'b0;
            timeout <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            prev <= botoes;
            case (estado)
                INICIAL: begin
                    if (jogar) estado <= PREPARA;
                end
                PREPARA: begin
                    seq    <= '0;
                    idx    <= '0;
                    limite <= nivel ? AW'(MAX_SEQ - 1) : AW'(MAX_SEQ / 2 - 1);
                    lfsr   <= (semente == 16'h0000) ? SEMENTE_PADRAO : semente;
                    estado <= NOVO;
                end
                NOVO: begin
                    lfsr   <= lfsr_nxt;
                    idx    <= '0;
                    timer  <= '0;
                    leds   <= onehot(primeiro);
                    estado <= MOSTRA;
                end
                MOSTRA: begin
                    if (timer == LED_FIM) begin
                        timer  <= '0;
                        leds   <= '0;
                        estado <= APAGA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGA: begin
                    if (timer == LED_FIM) begin
                        timer <= '0;
                        if (idx == seq) begin
                            idx    <= '0;
                            estado <= ESPERA;
                        end else begin
                            idx    <= idx + 1'b1;
                            leds   <= onehot(mem[idx + 1'b1]);
                            estado <= MOSTRA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ESPERA: begin
                    timer <= timer + 1'b1;
                    if (tem_jogada) begin
                        estado <= REGISTRA;
                    end else if (timer == TO_FIM) begin
                        timeout <= 1'b1;
                        pronto  <= 1'b1;
                        estado  <= FIM_TIMEOUT;
                    end
                end
                REGISTRA: begin
                    jogada <= botoes;
                    estado <= COMPARA;
                end
                COMPARA: begin
                    if (jogada != onehot(mem[idx])) begin
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                        estado <= FIM_PERDEU;
                    end else if (idx < seq) begin
                        idx    <= idx + 1'b1;
                        timer  <= '0;
                        estado <= ESPERA;
                    end else if (seq == limite) begin
                        ganhou <= 1'b1;
                        pronto <= 1'b1;
                        estado <= FIM_GANHOU;
                    end else begin
                        seq    <= seq + 1'b1;
                        estado <= NOVO;
                    end
                end
                FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                    leds <= '0;
                    if (jogar) begin
                        ganhou  <= 1'b0;
                        perdeu  <= 1'b0;
                        timeout <= 1'b0;
                        pronto  <= 1'b0;
                        estado  <= PREPARA;
                    end
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb_jogo_memoria_param
//   Scoreboard bench for jogo_memoria_param (N_BOTOES=4, MAX_SEQ=16,
//   TEMPO_LED=4, TIMEOUT_CICLOS=10). Stimulus pushes expected LED flashes and
//   end-of-game records into a queue; a monitor pops them as the DUT shows
//   each flash or raises pronto.
module tb_jogo_memoria_param;

    logic       clk;
    logic       rst;
    logic       jogar;
    logic       nivel;
    logic [15:0] semente;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic       pronto;
    logic [3:0] db_estado;
    logic [3:0] db_sequencia;
    logic [3:0] db_contagem;

    jogo_memoria_param #(
        .N_BOTOES(4),
        .MAX_SEQ(16),
        .TEMPO_LED(4),
        .TIMEOUT_CICLOS(10)
    ) dut (
        .clock(clk),
        .reset(rst),
        .jogar(jogar),
        .nivel(nivel),
        .semente(semente),
        .botoes(botoes),
        .leds(leds),
        .ganhou(ganhou),
        .perdeu(perdeu),
        .timeout(timeout),
        .pronto(pronto),
        .db_estado(db_estado),
        .db_sequencia(db_sequencia),
        .db_contagem(db_contagem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;    // 0: LED flash, 1: end of game
        logic [3:0] leds;
        int         len;
        logic [2:0] flags;   // {ganhou, perdeu, timeout}
        logic [3:0] estado;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Hand-computed element sequence for seed 16'hACE1 (semente = 0).
    logic [3:0] seq0 [9] = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                             4'b1000, 4'b1000, 4'b0010, 4'b0001};
    logic [3:0] tbl  [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flash(input logic [3:0] v);
        exp_t e;
        e.kind = 0; e.leds = v; e.len = 4; e.flags = 3'b000; e.estado = 4'h0; e.cyc = 0;
        q.push_back(e);
    endtask

    task automatic push_fim(input logic [2:0] f, input logic [3:0] est, input int c);
        exp_t e;
        e.kind = 1; e.leds = 4'h0; e.len = 0; e.flags = f; e.estado = est; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic push_replays(input int first, input int last);
        for (int r = first; r <= last; r++)
            for (int i = 0; i <= r; i++)
                push_flash(tbl[i]);
    endtask

    task automatic start_game(input logic [15:0] s, input logic nv);
        semente = s;
        nivel   = nv;
        jogar   = 1'b1;
        tick();
        jogar   = 1'b0;
        check("start_prepara", 32'(db_estado), 32'h1);
        check("start_pronto_clear", 32'({ganhou, perdeu, timeout, pronto}), 32'h0);
    endtask

    task automatic wait_espera(output int k);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (db_estado != 4'h5 && n < 300);
        check("espera_reached", 32'(db_estado), 32'h5);
        k = cyc;
    endtask

    task automatic press(input logic [3:0] b);
        botoes = b;
        repeat (3) tick();
        botoes = 4'b0000;
    endtask

    task automatic play_round(input int r, input bit last_win);
        int k;
        for (int i = 0; i <= r; i++) begin
            wait_espera(k);
            check("round_seq", 32'(db_sequencia), 32'(r));
            check("round_elem", 32'(db_contagem), 32'(i));
            if (last_win && i == r) push_fim(3'b100, 4'hA, cyc + 3);
            press(tbl[i]);
        end
    endtask

    task automatic finish_game(input logic [2:0] f, input logic [3:0] est);
        int n;
        n = 0;
        while (pronto !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("pronto_reached", 32'(pronto), 32'h1);
        repeat (3) tick();
        check("fim_flags_held", 32'({ganhou, perdeu, timeout, pronto}), 32'({f, 1'b1}));
        check("fim_estado_held", 32'(db_estado), 32'(est));
        check("fim_leds_dark", 32'(leds), 32'h0);
    endtask

    // Monitor: observes completed flashes and pronto rising edges.
    logic       in_flash = 1'b0;
    logic [3:0] fval = 4'h0;
    int         flen = 0;
    logic       prev_pronto = 1'b0;

    task automatic got(input int kind, input logic [3:0] v, input int len);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d leds 0x%0h len %0d, expected none (cycle %0d)",
                     kind, v, len, cyc);
        end else begin
            e = q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (kind == 0 && e.kind == 0) begin
                check("flash_leds", 32'(v), 32'(e.leds));
                check("flash_len", 32'(len), 32'(e.len));
            end else if (kind == 1 && e.kind == 1) begin
                check("fim_flags", 32'({ganhou, perdeu, timeout}), 32'(e.flags));
                check("fim_estado", 32'(db_estado), 32'(e.estado));
                check("fim_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_flash    = 1'b0;
                prev_pronto = 1'b0;
            end else begin
                if (in_flash && leds == fval) begin
                    flen++;
                end else begin
                    if (in_flash) got(0, fval, flen);
                    in_flash = (leds != 4'h0);
                    fval     = leds;
                    flen     = 1;
                end
                if (pronto && !prev_pronto) got(1, 4'h0, 0);
                prev_pronto = pronto;
            end
        end
    end

    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got no end of test, expected completion before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int k;
        int n;
        rst     = 1'b1;
        jogar   = 1'b0;
        nivel   = 1'b0;
        semente = 16'h0000;
        botoes  = 4'b0000;
        tbl     = seq0;
        repeat (3) tick();
        check("reset_estado", 32'(db_estado), 32'h0);
        check("reset_outputs", 32'({leds, ganhou, perdeu, timeout, pronto}), 32'h0);
        check("reset_db", 32'({db_sequencia, db_contagem}), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_estado", 32'(db_estado), 32'h0);

        // Reset in the middle of the first replay flash.
        start_game(16'h0000, 1'b0);
        n = 0;
        while (leds == 4'h0 && n < 100) begin
            tick();
            n++;
        end
        check("replay_before_reset", 32'(leds), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("after_reset_idle", 32'(db_estado), 32'h0);
        end
        check("after_reset_outputs", 32'({leds, ganhou, perdeu, timeout, pronto}), 32'h0);
        check("after_reset_db", 32'({db_sequencia, db_contagem}), 32'h0);

        // Full winning game, nivel=0: 8 rounds.
        start_game(16'h0000, 1'b0);
        push_replays(0, 7);
        for (int r = 0; r <= 7; r++) play_round(r, r == 7);
        finish_game(3'b100, 4'hA);

        // Wrong button in round 0; jogar is ignored while waiting.
        start_game(16'h0000, 1'b0);
        push_flash(4'b0010);
        wait_espera(k);
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        check("jogar_ignored", 32'(db_estado), 32'h5);
        push_fim(3'b010, 4'hB, cyc + 3);
        press(4'b0100);
        finish_game(3'b010, 4'hB);

        // Press on the last allowed cycle, then time out in round 1.
        start_game(16'h0000, 1'b0);
        push_replays(0, 1);
        wait_espera(k);
        repeat (9) tick();
        botoes = 4'b0010;
        tick();
        check("late_press_registra", 32'(db_estado), 32'h6);
        check("late_press_no_timeout", 32'(timeout), 32'h0);
        tick();
        tick();
        botoes = 4'b0000;
        wait_espera(k);
        push_fim(3'b001, 4'hC, k + 10);
        finish_game(3'b001, 4'hC);

        // Button held across two ESPERA phases, then a multi-hot press.
        start_game(16'h0000, 1'b0);
        push_replays(0, 2);
        play_round(0, 1'b0);
        play_round(1, 1'b0);
        wait_espera(k);
        press(4'b0010);
        wait_espera(k);
        botoes = 4'b0001;
        repeat (6) tick();
        check("hold_no_retrigger_estado", 32'(db_estado), 32'h5);
        check("hold_no_retrigger_elem", 32'(db_contagem), 32'h2);
        botoes = 4'b0000;
        tick();
        push_fim(3'b010, 4'hB, cyc + 3);
        press(4'b0011);
        finish_game(3'b010, 4'hB);

        // Non-zero seed 16'h0003: elements 3, 1.
        tbl[0] = 4'b1000;
        tbl[1] = 4'b0010;
        start_game(16'h0003, 1'b0);
        push_replays(0, 1);
        play_round(0, 1'b0);
        wait_espera(k);
        press(4'b1000);
        wait_espera(k);
        push_fim(3'b010, 4'hB, cyc + 3);
        press(4'b0100);
        finish_game(3'b010, 4'hB);

        // nivel=1: round 8 must follow round 7, then lose.
        tbl = seq0;
        start_game(16'h0000, 1'b1);
        push_replays(0, 8);
        for (int r = 0; r <= 7; r++) play_round(r, 1'b0);
        wait_espera(k);
        check("nivel1_round8", 32'(db_sequencia), 32'h8);
        push_fim(3'b010, 4'hB, cyc + 3);
        press(4'b0100);
        finish_game(3'b010, 4'hB);

        repeat (10) tick();
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
